// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: registered WIDTH-bit ALU with valid/ready handshakes.
// Single-cycle ops (ADD, SUB, AND, OR, XOR, SLT, NOR) load the output register
// on the accept edge. MUL is a sequential shift-add on operand magnitudes, one
// multiplier bit per clock, with the sign applied on the final iteration.
// The output register is single-entry and can drain and refill on the same edge.
//
// state | meaning
// IDLE  | no multiply pending, ops accepted when the output slot frees up
// CALC  | shift-add multiply iterating, input side stalled, busy asserted

module alu_pipe_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             busy
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] iter_cnt;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic             neg_prod;

    logic             accept;
    logic             accept_single;
    logic             accept_mul;
    logic             last_iter;

    logic [WIDTH-1:0] b_eff;
    logic             carry_in;
    logic [WIDTH:0]   sum_ext;
    logic             carry_into_msb;
    logic             a_lt_b;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [PW-1:0]    mul_step;
    logic [PW-1:0]    prod;
    logic [WIDTH:0]   prod_hi;
    logic [WIDTH-1:0] mul_res;
    logic             mul_v;

    // Handshake and status decode.
    always_comb begin
        in_ready      = (state != CALC) && (!out_valid || out_ready);
        busy          = (state == CALC);
        accept        = in_valid && in_ready;
        accept_mul    = accept && (op == OP_MUL);
        accept_single = accept && (op != OP_MUL);
        last_iter     = (state == CALC) && (iter_cnt == CNT_W'(WIDTH - 1));
    end

    // Single-cycle datapath: shared adder for ADD/SUB, signed compare for SLT.
    always_comb begin
        b_eff          = (op == OP_SUB) ? ~b : b;
        carry_in       = (op == OP_SUB);
        sum_ext        = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(carry_in);
        carry_into_msb = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum_ext[WIDTH-1];
        a_lt_b         = $signed(a) < $signed(b);

        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                alu_res = sum_ext[WIDTH-1:0];
                alu_c   = sum_ext[WIDTH];
                alu_v   = carry_into_msb ^ sum_ext[WIDTH];
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH - 1){1'b0}}, a_lt_b};
            OP_NOR:  alu_res = ~(a | b);
            default: alu_res = '0;
        endcase
    end

    // Multiply datapath: magnitudes at accept, final add and sign fix on the last step.
    always_comb begin
        abs_a    = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
        abs_b    = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
        mul_step = acc + (mplier[0] ? mcand : '0);
        prod     = neg_prod ? (~mul_step + PW'(1)) : mul_step;
        prod_hi  = prod[PW-1:WIDTH-1];
        mul_res  = prod[WIDTH-1:0];
        // Product fits in WIDTH bits only when the top WIDTH+1 bits are all equal.
        mul_v    = !((&prod_hi) || !(|prod_hi));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept_mul) state_nxt = CALC;
            CALC: if (last_iter)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift-add iteration registers; cleared by reset so an aborted multiply leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg_prod <= 1'b0;
        end else if (accept_mul) begin
            iter_cnt <= '0;
            acc      <= '0;
            mcand    <= {{WIDTH{1'b0}}, abs_a};
            mplier   <= abs_b;
            neg_prod <= a[WIDTH-1] ^ b[WIDTH-1];
        end else if (state == CALC) begin
            if (last_iter) begin
                iter_cnt <= '0;
            end else begin
                iter_cnt <= iter_cnt + CNT_W'(1);
            end
            acc    <= mul_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

    // Output register: load on single-cycle accept or multiply completion, else drain on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            flag_c    <= 1'b0;
            flag_v    <= 1'b0;
        end else if (accept_single) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            flag_z    <= (alu_res == '0);
            flag_n    <= alu_res[WIDTH-1];
            flag_c    <= alu_c;
            flag_v    <= alu_v;
        end else if (last_iter) begin
            out_valid <= 1'b1;
            result    <= mul_res;
            flag_z    <= (mul_res == '0);
            flag_n    <= mul_res[WIDTH-1];
            flag_c    <= 1'b0;
            flag_v    <= mul_v;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe_unit.sv
// Testbench for alu_pipe_unit (WIDTH=8): directed corner cases plus randomized
// traffic, with expected responses queued at issue time and popped by an
// independent monitor whenever the DUT hands a result over.

module tb_alu_pipe_unit;

    localparam int W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_NOR = 3'b111;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z;
    logic         flag_n;
    logic         flag_c;
    logic         flag_v;
    logic         busy;

    alu_pipe_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .busy      (busy)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb_q[$];
    int   pop_cyc[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   rand_ready = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the signed/unsigned operand values.
    function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xop);
        exp_t e;
        int   sa, sb, ua, ub, r, s;
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        ua = int'(xa);
        ub = int'(xb);
        e  = '0;
        r  = 0;
        case (xop)
            OP_ADD: begin
                r   = ua + ub;
                s   = sa + sb;
                e.c = (r > 255);
                e.v = (s > 127) || (s < -128);
            end
            OP_SUB: begin
                r   = ua - ub;
                s   = sa - sb;
                e.c = (ua >= ub);
                e.v = (s > 127) || (s < -128);
            end
            OP_AND: r = ua & ub;
            OP_OR:  r = ua | ub;
            OP_XOR: r = ua ^ ub;
            OP_SLT: r = (sa < sb) ? 1 : 0;
            OP_MUL: begin
                r   = sa * sb;
                e.v = (r > 127) || (r < -128);
            end
            default: r = ~(ua | ub);
        endcase
        e.res = r[W-1:0];
        e.z   = (e.res == 0);
        e.n   = e.res[W-1];
        return e;
    endfunction

    // Present an op at a negedge, hold until in_ready, queue its expectation, pass the accept edge.
    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [2:0] xop);
        int tries;
        @(negedge clk);
        in_valid = 1'b1;
        a        = xa;
        b        = xb;
        op       = xop;
        #1;
        tries = 0;
        while (!in_ready && tries < 60) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
        end else begin
            sb_q.push_back(model(xa, xb, xop));
            @(posedge clk);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitor: compare every handshaken result against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                pop_cyc.push_back(cyc);
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_result_flags", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'(e));
                end
            end
        end
    end

    // Randomized consumer back-pressure, enabled only during the random phase.
    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int lat;
        int busy_cnt;
        int k;
        logic [2:0] rop;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        op        = '0;
        #1;
        check("reset_state", 32'({out_valid, result, flag_z, flag_n, flag_c, flag_v, busy}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_reset", 32'(in_ready), 32'd1);

        // ADD overflow into the sign bit; result visible in the cycle after accept.
        send(8'h7F, 8'h01, OP_ADD);
        idle();
        #1;
        check("add_out_valid_next_cycle", 32'(out_valid), 32'd1);
        check("add_7f_01", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({8'h80, 4'b0101}));

        // SUB equal operands and SLT with a negative operand.
        send(8'h05, 8'h05, OP_SUB);
        idle();
        #1;
        check("sub_5_5", 32'({result, flag_z, flag_c, flag_v}), 32'({8'h00, 3'b110}));
        send(8'hFF, 8'h01, OP_SLT);
        idle();
        #1;
        check("slt_neg1_1", 32'(result), 32'h01);

        // MUL -3 * 4: busy window and exact latency.
        send(8'hFD, 8'h04, OP_MUL);
        idle();
        lat      = -1;
        busy_cnt = 0;
        for (k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            if (busy && !in_ready) busy_cnt++;
        end
        check("mul_latency_edges", 32'(lat), 32'd8);
        check("mul_busy_cycles", 32'(busy_cnt), 32'd8);
        check("mul_busy_clear", 32'(busy), 32'd0);
        check("mul_fd_04", 32'({result, flag_n, flag_v}), 32'({8'hF4, 2'b10}));

        // MUL most-negative squared, with in_valid offered throughout CALC (must be ignored).
        send(8'h80, 8'h80, OP_MUL);
        k = 0;
        forever begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            op       = OP_ADD;
            #1;
            k++;
            if (out_valid || k > 20) begin
                in_valid = 1'b0;
                break;
            end
        end
        check("mul_80_80_done", 32'(out_valid), 32'd1);
        check("mul_80_80", 32'({result, flag_z, flag_v}), 32'({8'h00, 2'b11}));

        // Back-pressure: result held three cycles, then drain and accept on one edge.
        @(negedge clk);
        out_ready = 1'b0;
        send(8'h10, 8'h20, OP_ADD);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = 8'h03;
            b        = 8'h04;
            op       = OP_ADD;
            #1;
            check("hold_stable", 32'({out_valid, in_ready, result}), 32'({2'b10, 8'h30}));
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("drain_ready", 32'(in_ready), 32'd1);
        sb_q.push_back(model(8'h03, 8'h04, OP_ADD));
        @(posedge clk);
        idle();
        #1;
        check("refill_result", 32'({out_valid, result}), 32'({1'b1, 8'h07}));

        // Back-to-back: four single-cycle ops, results on consecutive cycles.
        repeat (2) @(negedge clk);
        pop_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == OP_MUL) rop = OP_XOR;
            send(8'($urandom), 8'($urandom), rop);
        end
        idle();
        repeat (3) @(negedge clk);
        check("b2b_count", 32'(pop_cyc.size()), 32'd4);
        if (pop_cyc.size() == 4)
            check("b2b_consecutive", 32'(pop_cyc[3] - pop_cyc[0]), 32'd3);

        // Random traffic with random back-pressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)));
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        rand_ready = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        k = 0;
        while (sb_q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("random_drained", 32'(sb_q.size()), 32'd0);

        // Reset during a multiply: aborted, nothing appears.
        send(8'($urandom), 8'($urandom), OP_MUL);
        idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset_mid_mul", 32'({out_valid, busy}), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("ready_after_abort", 32'(in_ready), 32'd1);
        send(8'h01, 8'h01, OP_ADD);
        idle();
        #1;
        check("add_after_abort", 32'({out_valid, result}), 32'({1'b1, 8'h02}));

        repeat (3) @(negedge clk);
        check("final_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
